// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier rounding stage: default widths,
// rounding-mode encodings and the stage-1 register payload.
package mul_pkg;

    localparam int MUL_SIG_W = 48;  // normalized significand width
    localparam int MUL_OUT_W = 24;  // rounded significand width
    localparam int MUL_EXP_W = 10;  // biased exponent width

    typedef enum logic [2:0] {
        RND_RNE = 3'd0,  // nearest, ties to even
        RND_RTZ = 3'd1,  // toward zero
        RND_RDN = 3'd2,  // toward -inf
        RND_RUP = 3'd3,  // toward +inf
        RND_RMM = 3'd4   // nearest, ties away from zero
    } rnd_mode_e;

    // Everything stage 2 needs once the round decision has been made.
    typedef struct packed {
        logic [MUL_OUT_W-1:0] kept;
        logic                 inc;
        logic                 inexact;
        logic                 sign;
        logic [MUL_EXP_W-1:0] exp;
    } s1_payload_t;

endpackage

// File: rtl/mul_round_decide.sv
// Round-increment decision for one significand. Purely combinational.
// Encodings 5-7 fall back to round-to-nearest-even.
module mul_round_decide
    import mul_pkg::*;
(
    input  logic      lsb,      // kept[0]
    input  logic      guard,    // first discarded bit
    input  logic      sticky,   // OR of all lower discarded bits
    input  logic      sign,
    input  rnd_mode_e mode,
    output logic      inc,
    output logic      inexact
);

    // Select the increment for the requested rounding direction.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        inexact = guard | sticky;
        inc     = guard & (sticky | lsb);
        case (mode)
            RND_RTZ: inc = 1'b0;
            RND_RDN: inc = (guard | sticky) & sign;
            RND_RUP: inc = (guard | sticky) & ~sign;
            RND_RMM: inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/mul_round_stage.sv
// Two-stage rounding pipeline behind the multiplier's normalizing shifter.
// Stage 1 splits the product into kept/guard/sticky and decides the increment;
// stage 2 applies it, corrects the exponent on carry-out and flags overflow.
// Full valid/ready backpressure on both sides.
// Optional: define MUL_ROUND_MODES_EN to add the rnd_mode input (RNE, RTZ,
// RDN, RUP, RMM); otherwise the stage always rounds to nearest even.
module mul_round_stage
    import mul_pkg::*;
#(
    parameter int WIDTH  = MUL_SIG_W,
    parameter int OWIDTH = MUL_OUT_W,
    parameter int EWIDTH = MUL_EXP_W,
    parameter int EMAX   = 255
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MUL_ROUND_MODES_EN
    input  logic [2:0]        rnd_mode,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_sig,
    input  logic              in_sticky,
    input  logic              in_sign,
    input  logic [EWIDTH-1:0] in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] out_sig,
    output logic [EWIDTH-1:0] out_exp,
    output logic              out_sign,
    output logic              out_inexact,
    output logic              out_ovf
);

    // Overflow threshold widened by one bit so the compare also sees the
    // exponent carry-out.
    localparam logic [EWIDTH:0] EMAX_W = (EWIDTH+1)'(EMAX);

    logic        s1_valid;
    logic        s2_valid;
    logic        s2_adv;
    logic        accept;
    s1_payload_t s1_q;
    s1_payload_t s1_d;

    // Field split of the incoming product.
    logic [OWIDTH-1:0] kept;
    logic              g_bit;
    logic              s_bit;
    logic              dec_inc;
    logic              dec_inexact;
    rnd_mode_e         mode;

    // Stage-2 arithmetic.
    logic [OWIDTH:0]   sum;
    logic [OWIDTH-1:0] sig_n;
    logic [EWIDTH:0]   exp_n;   // MSB is the wrap carry

    assign kept  = in_sig[WIDTH-1 -: OWIDTH];
    assign g_bit = in_sig[WIDTH-OWIDTH-1];
    assign s_bit = (|in_sig[WIDTH-OWIDTH-2:0]) | in_sticky;

`ifdef MUL_ROUND_MODES_EN
    assign mode = rnd_mode_e'(rnd_mode);
`else
    assign mode = RND_RNE;
`endif

    mul_round_decide u_decide (
        .lsb     (kept[0]),
        .guard   (g_bit),
        .sticky  (s_bit),
        .sign    (in_sign),
        .mode    (mode),
        .inc     (dec_inc),
        .inexact (dec_inexact)
    );

    // Handshake: stage 2 takes a beat when it is empty or draining; stage 1
    // can take a new beat when it is empty or emptying into stage 2.
    assign s2_adv    = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_adv;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    // Assemble the stage-1 payload from the current input beat.
    always_comb begin
        s1_d         = '0;
        s1_d.kept    = kept;
        s1_d.inc     = dec_inc;
        s1_d.inexact = dec_inexact;
        s1_d.sign    = in_sign;
        s1_d.exp     = in_exp;
    end

    // Apply the increment; a carry-out renormalizes to 1.000... and bumps
    // the exponent, which is allowed to wrap.
    always_comb begin
        sum   = {1'b0, s1_q.kept} + (OWIDTH+1)'(s1_q.inc);
        sig_n = sum[OWIDTH-1:0];
        exp_n = {1'b0, s1_q.exp};
        if (sum[OWIDTH]) begin
            sig_n = {1'b1, {(OWIDTH-1){1'b0}}};
            exp_n = {1'b0, s1_q.exp} + (EWIDTH+1)'(1);
        end
    end

    // Occupancy of the two stages; reset discards any in-flight beats.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept)      s1_valid <= 1'b1;
            else if (s2_adv) s1_valid <= 1'b0;

            if (s2_adv)         s2_valid <= 1'b1;
            else if (out_ready) s2_valid <= 1'b0;
        end
    end

    // Stage-1 data register, loaded on accept.
    always_ff @(posedge clk) begin
        // NOTE: data registers are reset too, so the outputs read as zero
        // after reset rather than showing stale values.
        if (rst)         s1_q <= '0;
        else if (accept) s1_q <= s1_d;
    end

    // Stage-2 output registers, loaded on advance and held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sig     <= '0;
            out_exp     <= '0;
            out_sign    <= 1'b0;
            out_inexact <= 1'b0;
            out_ovf     <= 1'b0;
        end else if (s2_adv) begin
            out_sig     <= sig_n;
            out_exp     <= exp_n[EWIDTH-1:0];
            out_sign    <= s1_q.sign;
            out_inexact <= s1_q.inexact;
            out_ovf     <= exp_n[EWIDTH] | (exp_n >= EMAX_W);
        end
    end

endmodule
